// File: rtl/fetch_pkg.sv
// Shared types and default constants for the instruction fetch stage.
package fetch_pkg;

  localparam int unsigned FETCH_AW = 16;
  localparam int unsigned FETCH_IW = 16;

  localparam logic [15:0] FETCH_RESET_VECTOR = 16'h0000;
  localparam logic [15:0] FETCH_HALT_OPCODE  = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/next_pc_sel.sv
// Next-PC priority mux: reset vector, then redirect target, then increment on accept, else hold.
module next_pc_sel #(
  parameter int unsigned     AW           = 16,
  parameter logic [AW-1:0]   RESET_VECTOR = '0
) (
  input  logic          reset_i,
  input  logic          redirect_i,
  input  logic [AW-1:0] target_i,
  input  logic          accept_i,
  input  logic          halt_i,
  input  logic [AW-1:0] pc_i,
  output logic [AW-1:0] next_pc_o
);

  // A halting word is accepted but must not advance the PC, so it falls through to hold.
  always_comb begin
    next_pc_o = pc_i;
    if (reset_i) begin
      next_pc_o = RESET_VECTOR;
    end else if (redirect_i) begin
      next_pc_o = target_i;
    end else if (accept_i && !halt_i) begin
      next_pc_o = pc_i + AW'(1);
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage around the program counter with a one-entry output register for decode.
// Define FETCH_REDIRECT_EN to add the branch redirect/flush ports.
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter int unsigned   AW           = FETCH_AW,
  parameter int unsigned   IW           = FETCH_IW,
  parameter logic [AW-1:0] RESET_VECTOR = AW'(FETCH_RESET_VECTOR),
  parameter logic [IW-1:0] HALT_OPCODE  = IW'(FETCH_HALT_OPCODE)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [AW-1:0] pc_in,
  output logic [AW-1:0] next_pc,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_ack,
  input  logic [IW-1:0] mem_rdata,
  output logic          instr_valid,
  output logic [IW-1:0] instr_out,
  output logic [AW-1:0] instr_pc,
`ifdef FETCH_REDIRECT_EN
  input  logic          redirect_valid,
  input  logic [AW-1:0] redirect_target,
`endif
  input  logic          decode_ready
);

  fetch_state_e  state_q;
  logic          instrValid_q;
  logic [IW-1:0] instrOut_q;
  logic [AW-1:0] instrPc_q;

  logic          redirect;
  logic [AW-1:0] redirectTarget;
  logic          accept;
  logic          haltHit;
  logic          drain;

`ifdef FETCH_REDIRECT_EN
  assign redirect       = redirect_valid;
  assign redirectTarget = redirect_target;
`else
  assign redirect       = 1'b0;
  assign redirectTarget = '0;
`endif

  // Request only while the slot is empty or being drained this cycle.
  assign mem_req  = !reset && !redirect && (state_q == RUN) && (!instrValid_q || decode_ready);
  assign accept   = mem_req && mem_ack;
  assign haltHit  = accept && (mem_rdata == HALT_OPCODE);
  assign drain    = instrValid_q && decode_ready;
  assign mem_addr = pc_in;

  assign instr_valid = instrValid_q;
  assign instr_out   = instrOut_q;
  assign instr_pc    = instrPc_q;

  next_pc_sel #(
    .AW           (AW),
    .RESET_VECTOR (RESET_VECTOR)
  ) u_next_pc_sel (
    .reset_i    (reset),
    .redirect_i (redirect),
    .target_i   (redirectTarget),
    .accept_i   (accept),
    .halt_i     (haltHit),
    .pc_i       (pc_in),
    .next_pc_o  (next_pc)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      instrValid_q <= 1'b0;
      instrOut_q   <= '0;
      instrPc_q    <= '0;
    end else if (redirect) begin
      state_q      <= RUN;
      instrValid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: state_q <= RUN;
        RUN: begin
          if (accept) begin
            instrOut_q   <= mem_rdata;
            instrPc_q    <= pc_in;
            instrValid_q <= 1'b1;
            if (haltHit) state_q <= HALT;
          end else if (drain) begin
            instrValid_q <= 1'b0;
          end
        end
        HALT: if (drain) instrValid_q <= 1'b0;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch with a bench-side PC register and memory.
module tb_instruction_fetch;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_HALT = 2;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] pc;
  logic [15:0] next_pc;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        instr_valid;
  logic [15:0] instr_out;
  logic [15:0] instr_pc;
  logic        decode_ready;
  logic        redirV;
  logic [15:0] redirT;
  logic        pcLoad;
  logic [15:0] pcForce;
  logic        haltEn;
  logic [15:0] haltAddr;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int          mState;
  logic        mValid;
  logic [15:0] mOut;
  logic [15:0] mIpc;
  logic [15:0] mPc;
  logic        expReq;
  logic [15:0] expNext;
  logic        mAcc;
  logic        mHlt;

  instruction_fetch dut (
    .clock           (clock),
    .reset           (reset),
    .pc_in           (pc),
    .next_pc         (next_pc),
    .mem_req         (mem_req),
    .mem_addr        (mem_addr),
    .mem_ack         (mem_ack),
    .mem_rdata       (mem_rdata),
    .instr_valid     (instr_valid),
    .instr_out       (instr_out),
    .instr_pc        (instr_pc),
`ifdef FETCH_REDIRECT_EN
    .redirect_valid  (redirV),
    .redirect_target (redirT),
`endif
    .decode_ready    (decode_ready)
  );

  always #5 clock = ~clock;

  // Program counter register the fetch stage wraps around
  always @(posedge clock) pc <= pcLoad ? pcForce : next_pc;

  assign mem_rdata = (haltEn && mem_addr == haltAddr) ? 16'hFFFF : mem_addr + 16'h1000;

  function automatic logic [15:0] memAt(input logic [15:0] a);
    return (haltEn && a == haltAddr) ? 16'hFFFF : a + 16'h1000;
  endfunction

  task automatic modelEval();
    expReq  = !reset && !redirV && mState == M_RUN && (!mValid || decode_ready);
    mAcc    = expReq && mem_ack;
    mHlt    = mAcc && memAt(mPc) == 16'hFFFF;
    expNext = reset ? 16'h0000 : redirV ? redirT : (mAcc && !mHlt) ? mPc + 16'd1 : mPc;
  endtask

  task automatic modelUpdate();
    if (reset) begin
      mState = M_IDLE; mValid = 1'b0; mOut = 16'h0; mIpc = 16'h0;
    end else if (redirV) begin
      mState = M_RUN; mValid = 1'b0;
    end else if (mState == M_IDLE) begin
      mState = M_RUN;
    end else if (mAcc) begin
      mOut = memAt(mPc); mIpc = mPc; mValid = 1'b1;
      if (mHlt) mState = M_HALT;
    end else if (mValid && decode_ready) begin
      mValid = 1'b0;
    end
    mPc = pcLoad ? pcForce : expNext;
  endtask

  task automatic tick(input logic r, input logic a, input logic d);
    @(negedge clock);
    reset = r; mem_ack = a; decode_ready = d;
    #1;
    modelEval();
  endtask

  task automatic resetAndIdle();
    tick(1'b1, 1'b1, 1'b1); modelUpdate();
    tick(1'b1, 1'b1, 1'b1); modelUpdate();
    tick(1'b0, 1'b1, 1'b1); modelUpdate();
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      tick(1'b1, 1'b1, 1'b0);
      checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset mem_req got %0b want 0", mem_req); end
      checks++; if (next_pc !== 16'h0000) begin errors++; $display("FAIL reset next_pc got %h want 0000", next_pc); end
      if (i == 1) begin
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset instr_valid got %0b want 0", instr_valid); end
        checks++; if (instr_out !== 16'h0) begin errors++; $display("FAIL reset instr_out got %h want 0000", instr_out); end
        checks++; if (instr_pc !== 16'h0) begin errors++; $display("FAIL reset instr_pc got %h want 0000", instr_pc); end
      end
      modelUpdate();
    end
  endtask

  task automatic test_stream();
    tick(1'b0, 1'b1, 1'b1);
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL idle mem_req got %0b want 0", mem_req); end
    checks++; if (next_pc !== 16'h0000) begin errors++; $display("FAIL idle next_pc got %h want 0000", next_pc); end
    modelUpdate();
    for (int i = 0; i < 6; i++) begin
      tick(1'b0, 1'b1, 1'b1);
      checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL stream mem_req got %0b want 1", mem_req); end
      checks++; if (next_pc !== 16'(i + 1)) begin errors++; $display("FAIL stream next_pc got %h want %h", next_pc, 16'(i + 1)); end
      if (i > 0) begin
        checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL stream instr_valid got %0b want 1", instr_valid); end
        checks++; if (instr_pc !== 16'(i - 1)) begin errors++; $display("FAIL stream instr_pc got %h want %h", instr_pc, 16'(i - 1)); end
        checks++; if (instr_out !== 16'(16'h1000 + i - 1)) begin errors++; $display("FAIL stream instr_out got %h want %h", instr_out, 16'(16'h1000 + i - 1)); end
      end
      modelUpdate();
    end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b1, 1'b0);
      checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL stall mem_req got %0b want 0", mem_req); end
      checks++; if (next_pc !== 16'h0006 || next_pc !== pc) begin errors++; $display("FAIL stall next_pc got %h want 0006", next_pc); end
      checks++; if (instr_out !== 16'h1005 || instr_valid !== 1'b1) begin errors++; $display("FAIL stall instr_out got %h/%0b want 1005/1", instr_out, instr_valid); end
      modelUpdate();
    end
    tick(1'b0, 1'b1, 1'b1);
    checks++; if (mem_req !== 1'b1 || next_pc !== 16'h0007) begin errors++; $display("FAIL resume req/next_pc got %0b/%h want 1/0007", mem_req, next_pc); end
    modelUpdate();
    tick(1'b0, 1'b1, 1'b1);
    checks++; if (instr_pc !== 16'h0006 || instr_out !== 16'h1006) begin errors++; $display("FAIL resume instr got %h@%h want 1006@0006", instr_out, instr_pc); end
    modelUpdate();
  endtask

  task automatic test_ack_delay();
    resetAndIdle();
    for (int i = 0; i < 5; i++) begin tick(1'b0, 1'b1, 1'b1); modelUpdate(); end
    for (int i = 0; i < 2; i++) begin
      tick(1'b0, 1'b0, 1'b1);
      checks++; if (next_pc !== 16'h0005 || mem_req !== 1'b1) begin errors++; $display("FAIL ackwait next_pc/req got %h/%0b want 0005/1", next_pc, mem_req); end
      modelUpdate();
    end
    tick(1'b0, 1'b1, 1'b1);
    checks++; if (next_pc !== 16'h0006) begin errors++; $display("FAIL ackhit next_pc got %h want 0006", next_pc); end
    modelUpdate();
    tick(1'b0, 1'b0, 1'b1);
    checks++; if (instr_pc !== 16'h0005 || instr_out !== 16'h1005 || instr_valid !== 1'b1) begin errors++; $display("FAIL ackhit instr got %h@%h v%0b want 1005@0005 v1", instr_out, instr_pc, instr_valid); end
    modelUpdate();
  endtask

  task automatic test_wrap();
    resetAndIdle();
    pcLoad = 1'b1; pcForce = 16'hFFFF;
    tick(1'b0, 1'b0, 1'b1); modelUpdate();
    pcLoad = 1'b0;
    tick(1'b0, 1'b1, 1'b1);
    checks++; if (mem_addr !== 16'hFFFF || mem_req !== 1'b1) begin errors++; $display("FAIL wrap addr/req got %h/%0b want FFFF/1", mem_addr, mem_req); end
    checks++; if (next_pc !== 16'h0000) begin errors++; $display("FAIL wrap next_pc got %h want 0000", next_pc); end
    modelUpdate();
    tick(1'b0, 1'b0, 1'b1);
    checks++; if (instr_pc !== 16'hFFFF || instr_out !== 16'h0FFF) begin errors++; $display("FAIL wrap instr got %h@%h want 0FFF@FFFF", instr_out, instr_pc); end
    modelUpdate();
  endtask

  task automatic test_halt();
    haltEn = 1'b1; haltAddr = 16'h0003;
    resetAndIdle();
    for (int i = 0; i < 4; i++) begin tick(1'b0, 1'b1, 1'b1); modelUpdate(); end
    checks++; if (mPc !== 16'h0003) begin errors++; $display("FAIL halt model pc got %h want 0003", mPc); end
    for (int i = 0; i < 10; i++) begin
      tick(1'b0, 1'b1, 1'b1);
      checks++; if (mem_req !== 1'b0 || next_pc !== 16'h0003) begin errors++; $display("FAIL halt req/next_pc got %0b/%h want 0/0003", mem_req, next_pc); end
      if (i == 0) begin
        checks++; if (instr_out !== 16'hFFFF || instr_pc !== 16'h0003 || instr_valid !== 1'b1) begin errors++; $display("FAIL halt instr got %h@%h v%0b want FFFF@0003 v1", instr_out, instr_pc, instr_valid); end
      end
      if (i == 1) begin
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL halt drain instr_valid got %0b want 0", instr_valid); end
      end
      modelUpdate();
    end
    haltEn = 1'b0;
  endtask

  task automatic test_random();
    logic r;
    resetAndIdle();
    for (int i = 0; i < 300; i++) begin
      r = ($urandom_range(39) == 0);
      tick(r, 1'($urandom_range(1)), ($urandom_range(9) < 6));
      checks++; if (mem_req !== expReq) begin errors++; $display("FAIL rand mem_req cyc %0d got %0b want %0b", i, mem_req, expReq); end
      checks++; if (next_pc !== expNext) begin errors++; $display("FAIL rand next_pc cyc %0d got %h want %h", i, next_pc, expNext); end
      checks++; if (instr_valid !== mValid) begin errors++; $display("FAIL rand instr_valid cyc %0d got %0b want %0b", i, instr_valid, mValid); end
      checks++; if (instr_out !== mOut || instr_pc !== mIpc) begin errors++; $display("FAIL rand instr cyc %0d got %h@%h want %h@%h", i, instr_out, instr_pc, mOut, mIpc); end
      modelUpdate();
    end
  endtask

`ifdef FETCH_REDIRECT_EN
  task automatic test_redirect();
    resetAndIdle();
    for (int i = 0; i < 3; i++) begin tick(1'b0, 1'b1, 1'b1); modelUpdate(); end
    redirV = 1'b1; redirT = 16'h0040;
    tick(1'b0, 1'b1, 1'b1);
    checks++; if (mem_req !== 1'b0 || next_pc !== 16'h0040) begin errors++; $display("FAIL redir req/next_pc got %0b/%h want 0/0040", mem_req, next_pc); end
    modelUpdate();
    redirV = 1'b0;
    tick(1'b0, 1'b1, 1'b1);
    checks++; if (instr_valid !== 1'b0 || mem_addr !== 16'h0040) begin errors++; $display("FAIL redir flush v/addr got %0b/%h want 0/0040", instr_valid, mem_addr); end
    modelUpdate();
    tick(1'b0, 1'b1, 1'b1);
    checks++; if (instr_pc !== 16'h0040 || instr_valid !== 1'b1) begin errors++; $display("FAIL redir target instr_pc got %h want 0040", instr_pc); end
    modelUpdate();
    haltEn = 1'b1; haltAddr = 16'h0042;
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, 1'b1, 1'b1);
      checks++; if (mem_req !== expReq || next_pc !== expNext) begin errors++; $display("FAIL redir halt req/next_pc got %0b/%h want %0b/%h", mem_req, next_pc, expReq, expNext); end
      modelUpdate();
    end
    checks++; if (mState != M_HALT || pc !== 16'h0042) begin errors++; $display("FAIL redir halt pc got %h want 0042", pc); end
    redirV = 1'b1; redirT = 16'h0010;
    tick(1'b0, 1'b0, 1'b1);
    checks++; if (next_pc !== 16'h0010) begin errors++; $display("FAIL redir halt next_pc got %h want 0010", next_pc); end
    modelUpdate();
    redirV = 1'b0; haltEn = 1'b0;
    tick(1'b0, 1'b1, 1'b1);
    checks++; if (mem_req !== 1'b1 || next_pc !== 16'h0011) begin errors++; $display("FAIL redir resume req/next_pc got %0b/%h want 1/0011", mem_req, next_pc); end
    modelUpdate();
    tick(1'b0, 1'b1, 1'b1);
    checks++; if (instr_pc !== 16'h0010) begin errors++; $display("FAIL redir resume instr_pc got %h want 0010", instr_pc); end
    modelUpdate();
  endtask
`endif

  initial begin
    reset = 1'b1; mem_ack = 1'b0; decode_ready = 1'b0;
    redirV = 1'b0; redirT = 16'h0; pcLoad = 1'b0; pcForce = 16'h0;
    haltEn = 1'b0; haltAddr = 16'h0;
    mState = M_IDLE; mValid = 1'b0; mOut = 16'h0; mIpc = 16'h0; mPc = 16'h0;
    test_reset();
    test_stream();
    test_stall();
    test_ack_delay();
    test_wrap();
    test_halt();
`ifdef FETCH_REDIRECT_EN
    test_redirect();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
